seq_gen: RTL and testbench



---
 rtl/seq_gen.sv | 147 ++++++++++++++
 tb/tb_seq_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a latched frame out MSB-first, repeats it with idle gaps, then pulses Done.
// Optional even-parity bit per frame when SEQ_GEN_PARITY_EN is defined.
module seq_gen #(
  parameter int unsigned PAT_LEN = 8,
  parameter int unsigned GAP_LEN = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Abort,
  input  logic [PAT_LEN-1:0] Pattern,
  input  logic [CNT_W-1:0]   Count,
  output logic               Out1,
  output logic               Busy,
  output logic               Done
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned FW = PAT_LEN + 1;
`else
  localparam int unsigned FW = PAT_LEN;
`endif
  localparam int unsigned BW = $clog2(FW);
  localparam int unsigned GW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [BW-1:0] BIT_INIT = BW'(FW - 1);
  localparam logic [GW-1:0] GAP_INIT = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;

  logic [1:0]       state, state_d;
  logic [FW-1:0]    sr, sr_d;
  logic [FW-1:0]    frame, frame_d;
  logic [BW-1:0]    bitcnt, bit_d;
  logic [CNT_W-1:0] rep, rep_d;
  logic [GW-1:0]    gapcnt, gap_d;
  logic             pend, pend_d;
  logic             out1_d, busy_d, done_d;
  logic [FW-1:0]    latched;

  // Frame as captured at Start; parity bit computed once here
`ifdef SEQ_GEN_PARITY_EN
  assign latched = {Pattern, ^Pattern};
`else
  assign latched = Pattern;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      sr     <= '0;
      frame  <= '0;
      bitcnt <= '0;
      rep    <= '0;
      gapcnt <= '0;
      pend   <= 1'b0;
      Out1   <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      state  <= state_d;
      sr     <= sr_d;
      frame  <= frame_d;
      bitcnt <= bit_d;
      rep    <= rep_d;
      gapcnt <= gap_d;
      pend   <= pend_d;
      Out1   <= out1_d;
      Busy   <= busy_d;
      Done   <= done_d;
    end
  end

  // Outputs reflect the state one cycle late, so Done lands on the first all-idle cycle
  always_comb begin
    state_d = state;
    sr_d    = sr;
    frame_d = frame;
    bit_d   = bitcnt;
    rep_d   = rep;
    gap_d   = gapcnt;
    pend_d  = 1'b0;
    out1_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = pend;

    case (state)
      S_IDLE: begin
        if (Start) begin
          frame_d = latched;
          sr_d    = latched;
          rep_d   = (Count == '0) ? CNT_W'(1) : Count;
          bit_d   = BIT_INIT;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        out1_d = sr[FW-1];
        busy_d = 1'b1;
        if (Abort) begin
          state_d = S_IDLE;
        end else begin
          sr_d  = {sr[FW-2:0], 1'b0};
          bit_d = bitcnt - BW'(1);
          if (bitcnt == '0) begin
            if (rep > CNT_W'(1)) begin
              rep_d = rep - CNT_W'(1);
              if (GAP_LEN == 0) begin
                sr_d  = frame;
                bit_d = BIT_INIT;
              end else begin
                gap_d   = GAP_INIT;
                state_d = S_GAP;
              end
            end else begin
              state_d = S_IDLE;
              pend_d  = 1'b1;
            end
          end
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (Abort) begin
          state_d = S_IDLE;
        end else if (gapcnt == '0) begin
          sr_d    = frame;
          bit_d   = BIT_INIT;
          state_d = S_SHIFT;
        end else begin
          gap_d = gapcnt - GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: reset, single/repeated frames, abort, back-to-back, optional parity.
// Cycle c of a transfer is the cycle after the c-th rising edge, edge 0 being the one that accepts Start.
module tb_seq_gen;

  localparam int G = 2;
`ifdef SEQ_GEN_PARITY_EN
  localparam int F = 9;
  localparam logic [32:0] FR_A5 = {24'd0, 8'hA5, 1'b0};
  localparam logic [32:0] FR_C3 = {24'd0, 8'hC3, 1'b0};
`else
  localparam int F = 8;
  localparam logic [32:0] FR_A5 = {25'd0, 8'hA5};
  localparam logic [32:0] FR_C3 = {25'd0, 8'hC3};
`endif

  logic       CLK = 1'b0;
  logic       RST, Start, Abort;
  logic [7:0] Pattern;
  logic [3:0] Count;
  logic       Out1, Busy, Done;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seq_gen #(.PAT_LEN(8), .GAP_LEN(G), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
    .Pattern(Pattern), .Count(Count),
    .Out1(Out1), .Busy(Busy), .Done(Done)
  );

  // Expected serial bit for cycle c of an n-frame transfer of frame fr
  function automatic logic exp_bit(input logic [32:0] fr, input int c, input int n);
    int p;
    if (c < 1 || c >= 1 + n*F + (n-1)*G) return 1'b0;
    p = (c - 1) % (F + G);
    if (p < F) return fr[F-1-p];
    return 1'b0;
  endfunction

  // Start pulse sampled by edge 0; returns at the cycle-0 falling edge
  task automatic launch(input logic [7:0] pat, input logic [3:0] cnt);
    @(negedge CLK);
    Start = 1'b1; Pattern = pat; Count = cnt;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b1; Abort = 1'b0; Pattern = 8'hFF; Count = 4'd1;
    repeat (2) @(negedge CLK);
    checks++; if (Out1 !== 1'b0) begin errors++; $display("FAIL reset_por_out1 got %b exp 0", Out1); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_por_busy got %b exp 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_por_done got %b exp 0", Done); end
    RST = 1'b0; Start = 1'b0;
    launch(8'hFF, 4'd2);
    repeat (3) @(negedge CLK);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %b exp 1", Busy); end
    checks++; if (Out1 !== 1'b1) begin errors++; $display("FAIL reset_pre_out1 got %b exp 1", Out1); end
    RST = 1'b1; Start = 1'b1;
    for (int c = 4; c <= 5; c++) begin
      @(negedge CLK);
      checks++; if (Out1 !== 1'b0) begin errors++; $display("FAIL reset_mid_out1 c=%0d got %b exp 0", c, Out1); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy c=%0d got %b exp 0", c, Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_mid_done c=%0d got %b exp 0", c, Done); end
    end
    RST = 1'b0; Start = 1'b0;
    for (int c = 6; c <= 10; c++) begin
      @(negedge CLK);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored_busy c=%0d got %b exp 0", c, Busy); end
      checks++; if (Out1 !== 1'b0) begin errors++; $display("FAIL reset_start_ignored_out1 c=%0d got %b exp 0", c, Out1); end
    end
  endtask

  task automatic test_single(input logic [3:0] cnt);
    launch(8'hA5, cnt);
    for (int c = 1; c <= F + 2; c++) begin
      @(negedge CLK);
      checks++; if (Out1 !== exp_bit(FR_A5, c, 1)) begin errors++; $display("FAIL single_out1 cnt=%0d c=%0d got %b exp %b", cnt, c, Out1, exp_bit(FR_A5, c, 1)); end
      checks++; if (Busy !== (c <= F)) begin errors++; $display("FAIL single_busy cnt=%0d c=%0d got %b exp %b", cnt, c, Busy, (c <= F)); end
      checks++; if (Done !== (c == F + 1)) begin errors++; $display("FAIL single_done cnt=%0d c=%0d got %b exp %b", cnt, c, Done, (c == F + 1)); end
    end
  endtask

  task automatic test_repeat();
    int dc;
    dc = 1 + 3*F + 2*G;
    launch(8'hC3, 4'd3);
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge CLK);
      checks++; if (Out1 !== exp_bit(FR_C3, c, 3)) begin errors++; $display("FAIL repeat_out1 c=%0d got %b exp %b", c, Out1, exp_bit(FR_C3, c, 3)); end
      checks++; if (Busy !== (c < dc)) begin errors++; $display("FAIL repeat_busy c=%0d got %b exp %b", c, Busy, (c < dc)); end
      checks++; if (Done !== (c == dc)) begin errors++; $display("FAIL repeat_done c=%0d got %b exp %b", c, Done, (c == dc)); end
      if (c == 5) begin Pattern = 8'hFF; Count = 4'd1; end
    end
  endtask

  task automatic test_abort();
    launch(8'hFF, 4'd3);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (c <= 3) begin
        checks++; if (Out1 !== 1'b1) begin errors++; $display("FAIL abort_pre_out1 c=%0d got %b exp 1", c, Out1); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy c=%0d got %b exp 1", c, Busy); end
      end
      if (c >= 5) begin
        checks++; if (Out1 !== 1'b0) begin errors++; $display("FAIL abort_out1 c=%0d got %b exp 0", c, Out1); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy c=%0d got %b exp 0", c, Busy); end
      end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL abort_done c=%0d got %b exp 0", c, Done); end
      if (c == 3) Abort = 1'b1;
      if (c == 4) Abort = 1'b0;
    end
    // Start and Abort together in IDLE: Start wins
    Start = 1'b1; Abort = 1'b1; Pattern = 8'hA5; Count = 4'd1;
    @(negedge CLK);
    Start = 1'b0; Abort = 1'b0;
    for (int c = 1; c <= F + 1; c++) begin
      @(negedge CLK);
      checks++; if (Out1 !== exp_bit(FR_A5, c, 1)) begin errors++; $display("FAIL abort_restart_out1 c=%0d got %b exp %b", c, Out1, exp_bit(FR_A5, c, 1)); end
      checks++; if (Done !== (c == F + 1)) begin errors++; $display("FAIL abort_restart_done c=%0d got %b exp %b", c, Done, (c == F + 1)); end
    end
  endtask

  task automatic test_back_to_back();
    logic eo, eb, ed;
    @(negedge CLK);
    Start = 1'b1; Pattern = 8'hA5; Count = 4'd1;
    for (int c = 0; c <= 2*F + 3; c++) begin
      @(negedge CLK);
      if (c >= 1) begin
        eo = (c <= F + 1) ? exp_bit(FR_A5, c, 1) : exp_bit(FR_A5, c - (F + 1), 1);
        eb = (c <= F) || (c >= F + 2 && c <= 2*F + 1);
        ed = (c == F + 1) || (c == 2*F + 2);
        checks++; if (Out1 !== eo) begin errors++; $display("FAIL b2b_out1 c=%0d got %b exp %b", c, Out1, eo); end
        checks++; if (Busy !== eb) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, Busy, eb); end
        checks++; if (Done !== ed) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, Done, ed); end
      end
      if (c == F + 1) Start = 1'b0;
    end
  endtask

`ifdef SEQ_GEN_PARITY_EN
  task automatic test_parity();
    launch(8'hA5, 4'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 9) begin
        checks++; if (Out1 !== 1'b0) begin errors++; $display("FAIL parity_a5_bit got %b exp 0", Out1); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL parity_a5_busy got %b exp 1", Busy); end
      end
      if (c == 10) begin
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL parity_a5_done got %b exp 1", Done); end
      end
    end
    launch(8'h07, 4'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 8 || c == 9) begin
        checks++; if (Out1 !== 1'b1) begin errors++; $display("FAIL parity_07_bit c=%0d got %b exp 1", c, Out1); end
      end
      if (c == 10) begin
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL parity_07_done got %b exp 1", Done); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(4'd1);
    test_single(4'd0);
    test_repeat();
    test_abort();
    test_back_to_back();
`ifdef SEQ_GEN_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
